uart_program_loader: RTL and testbench



---
 rtl/uart_program_loader_pkg.sv | 24 ++
 rtl/uart_program_loader_rx.sv | 107 ++++++++++
 rtl/uart_program_loader.sv | 136 +++++++++++++
 tb/tb_uart_program_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_program_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
package uart_program_loader_pkg;

    localparam logic [7:0]  LDR_SYNC = 8'hA5;
    localparam int unsigned WORD_W   = 16;
    localparam int unsigned BYTE_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
        CHECK,
        DONE
    } ldr_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_program_loader_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, valid/framing-error pulses.
module uart_rx
    import uart_program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx,
    output logic [BYTE_W-1:0] rx_data,
    output logic              byte_valid,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic rx_meta, rx_sync, rx_prev;

    rx_state_t         state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [2:0]        bit_idx, bit_idx_d;
    logic [BYTE_W-1:0] shift_d;
    logic              byte_valid_d, frame_err_d;

    // Synchronizer plus one extra stage for falling-edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rx_data    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bit_idx    <= bit_idx_d;
            rx_data    <= shift_d;
            byte_valid <= byte_valid_d;
            frame_err  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        bit_idx_d    = bit_idx;
        shift_d      = rx_data;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_sync && rx_prev) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync, rx_data[BYTE_W-1:1]};
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_d        = '0;
                    state_d      = RX_IDLE;
                    byte_valid_d = rx_sync;
                    frame_err_d  = !rx_sync;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a framed program image over UART, writes it to program memory, holds the core until verified.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT    = 104,
    parameter int unsigned INST_ADDR_WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_rx,
    output logic                       o_core_hold,
    output logic                       o_wr_en,
    output logic [INST_ADDR_WIDTH-1:0] o_wr_addr,
    output logic [WORD_W-1:0]          o_wr_data,
    output logic                       o_done,
    output logic                       o_error
);

    logic [BYTE_W-1:0] rx_data;
    logic              byte_valid;
    logic              frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_rx      (i_rx),
        .rx_data   (rx_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    ldr_state_t                 state, state_d;
    logic [BYTE_W-1:0]          count_q, count_d;
    logic [BYTE_W-1:0]          word_cnt, word_cnt_d;
    logic [BYTE_W-1:0]          hi_q, hi_d;
    logic [BYTE_W-1:0]          csum, csum_d;
    logic                       hold_d, wr_en_d, done_d, error_d;
    logic [INST_ADDR_WIDTH-1:0] wr_addr_d;
    logic [WORD_W-1:0]          wr_data_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            count_q     <= '0;
            word_cnt    <= '0;
            hi_q        <= '0;
            csum        <= '0;
            o_core_hold <= 1'b1;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            state       <= state_d;
            count_q     <= count_d;
            word_cnt    <= word_cnt_d;
            hi_q        <= hi_d;
            csum        <= csum_d;
            o_core_hold <= hold_d;
            o_wr_en     <= wr_en_d;
            o_wr_addr   <= wr_addr_d;
            o_wr_data   <= wr_data_d;
            o_done      <= done_d;
            o_error     <= error_d;
        end
    end

    always_comb begin
        state_d    = state;
        count_d    = count_q;
        word_cnt_d = word_cnt;
        hi_d       = hi_q;
        csum_d     = csum;
        hold_d     = o_core_hold;
        wr_en_d    = 1'b0;
        wr_addr_d  = o_wr_addr;
        wr_data_d  = o_wr_data;
        done_d     = o_done;
        error_d    = o_error;

        // Address advances the cycle after each strobe
        if (o_wr_en) begin
            wr_addr_d = o_wr_addr + INST_ADDR_WIDTH'(1);
        end

        if (frame_err && state != IDLE && state != DONE) begin
            error_d = 1'b1;
            state_d = IDLE;
        end else if (byte_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == LDR_SYNC) begin
                        csum_d    = '0;
                        error_d   = 1'b0;
                        wr_addr_d = '0;
                        state_d   = COUNT;
                    end
                end
                COUNT: begin
                    count_d    = rx_data;
                    csum_d     = rx_data;
                    word_cnt_d = '0;
                    state_d    = (rx_data == '0) ? CHECK : HI;
                end
                HI: begin
                    hi_d    = rx_data;
                    csum_d  = csum + rx_data;
                    state_d = LO;
                end
                LO: begin
                    csum_d     = csum + rx_data;
                    wr_en_d    = 1'b1;
                    wr_data_d  = {hi_q, rx_data};
                    word_cnt_d = word_cnt + BYTE_W'(1);
                    state_d    = (9'(word_cnt) + 9'd1 == 9'(count_q)) ? CHECK : HI;
                end
                CHECK: begin
                    if (rx_data == csum) begin
                        hold_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: vector table of frames plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_uart_program_loader;

    localparam int unsigned CPB = 8;
    localparam int unsigned AW  = 8;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_rx  = 1'b1;
    logic          o_core_hold, o_wr_en, o_done, o_error;
    logic [AW-1:0] o_wr_addr;
    logic [15:0]   o_wr_data;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .INST_ADDR_WIDTH(AW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx       (i_rx),
        .o_core_hold(o_core_hold),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_done     (o_done),
        .o_error    (o_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        string       name;
        int          nb;
        logic [7:0]  b [8];
        int          bad_idx;
        int          nw;
        logic [7:0]  wa [2];
        logic [15:0] wd [2];
        logic        e_done;
        logic        e_err;
        logic        e_hold;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[5];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic prev_wr = 1'b0;
    logic pre_done, pre_hold, pre_err, pre_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Sends one 8N1 byte; snapshots outputs one cycle before the frame ends
    task automatic send_byte(input logic [7:0] d, input bit stop_ok);
        logic [9:0] bits;
        bits = {stop_ok ? 1'b1 : 1'b0, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            i_rx = bits[i];
            if (i == 9) begin
                repeat (CPB - 1) @(posedge i_clk);
                #1;
                pre_done = o_done;
                pre_hold = o_core_hold;
                pre_err  = o_error;
                pre_wr   = o_wr_en;
                @(posedge i_clk);
                #1;
            end else begin
                repeat (CPB) @(posedge i_clk);
                #1;
            end
        end
        i_rx = 1'b1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_rx  = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_hold", o_core_hold, 1);
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_wr_addr", o_wr_addr, 0);
        chk("rst_wr_data", o_wr_data, 0);
        chk("rst_done", o_done, 0);
        chk("rst_error", o_error, 0);
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    task automatic settle_and_check(input string tag, input logic e_done, input logic e_err, input logic e_hold);
        repeat (4) @(posedge i_clk);
        #1;
        chk({tag, "_pending_writes"}, exp_q.size(), 0);
        chk({tag, "_done"}, o_done, e_done);
        chk({tag, "_error"}, o_error, e_err);
        chk({tag, "_hold"}, o_core_hold, e_hold);
    endtask

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_wr_en) begin
                chk("wr_en_single_cycle", prev_wr, 0);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_write: addr %0h data %0h, expected no write", o_wr_addr, o_wr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", o_wr_addr, e.addr);
                    chk("wr_data", o_wr_data, e.data);
                end
            end
            prev_wr = o_wr_en;
        end else begin
            prev_wr = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0].name = "good_load"; vecs[0].nb = 7; vecs[0].bad_idx = -1;
        vecs[0].b  = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0, 8'h00};
        vecs[0].nw = 2; vecs[0].wa = '{8'h00, 8'h01}; vecs[0].wd = '{16'h1234, 16'hABCD};
        vecs[0].e_done = 1; vecs[0].e_err = 0; vecs[0].e_hold = 0;

        vecs[1].name = "bad_csum"; vecs[1].nb = 5; vecs[1].bad_idx = -1;
        vecs[1].b  = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00};
        vecs[1].nw = 1; vecs[1].wa = '{8'h00, 8'h00}; vecs[1].wd = '{16'h0001, 16'h0000};
        vecs[1].e_done = 0; vecs[1].e_err = 1; vecs[1].e_hold = 1;

        vecs[2].name = "empty_noise"; vecs[2].nb = 5; vecs[2].bad_idx = -1;
        vecs[2].b  = '{8'h3C, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2].nw = 0; vecs[2].wa = '{8'h00, 8'h00}; vecs[2].wd = '{16'h0000, 16'h0000};
        vecs[2].e_done = 1; vecs[2].e_err = 0; vecs[2].e_hold = 0;

        vecs[3].name = "frame_err"; vecs[3].nb = 3; vecs[3].bad_idx = 2;
        vecs[3].b  = '{8'hA5, 8'h01, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].nw = 0; vecs[3].wa = '{8'h00, 8'h00}; vecs[3].wd = '{16'h0000, 16'h0000};
        vecs[3].e_done = 0; vecs[3].e_err = 1; vecs[3].e_hold = 1;

        vecs[4].name = "empty_bad_csum"; vecs[4].nb = 3; vecs[4].bad_idx = -1;
        vecs[4].b  = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4].nw = 0; vecs[4].wa = '{8'h00, 8'h00}; vecs[4].wd = '{16'h0000, 16'h0000};
        vecs[4].e_done = 0; vecs[4].e_err = 1; vecs[4].e_hold = 1;

        @(posedge i_clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int w = 0; w < vecs[v].nw; w++) push_wr(vecs[v].wa[w], vecs[v].wd[w]);
            for (int k = 0; k < vecs[v].nb; k++) send_byte(vecs[v].b[k], k != vecs[v].bad_idx);
            settle_and_check(vecs[v].name, vecs[v].e_done, vecs[v].e_err, vecs[v].e_hold);
        end

        // Reset in the middle of a frame, then a full load from address 0
        do_reset();
        send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h12, 1);
        do_reset();
        push_wr(8'h00, 16'h1234); push_wr(8'h01, 16'hABCD);
        send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h12, 1);
        send_byte(8'h34, 1); send_byte(8'hAB, 1); send_byte(8'hCD, 1);
        send_byte(8'hC0, 1);
        settle_and_check("mid_reset_reload", 1, 0, 0);

        // Failed frame, then a good frame without reset: error clears on sync, result timing exact
        do_reset();
        push_wr(8'h00, 16'h0001);
        send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h00, 1);
        send_byte(8'h01, 1);
        chk("lo_strobe_not_early", pre_wr, 0);
        chk("lo_strobe_next_cycle", o_wr_en, 1);
        send_byte(8'hFF, 1);
        chk("bad_err_not_early", pre_err, 0);
        chk("bad_err_next_cycle", o_error, 1);
        chk("bad_hold_kept", o_core_hold, 1);
        send_byte(8'hA5, 1);
        chk("err_before_sync", pre_err, 1);
        chk("err_cleared_by_sync", o_error, 0);
        push_wr(8'h00, 16'h1234); push_wr(8'h01, 16'hABCD);
        send_byte(8'h02, 1); send_byte(8'h12, 1); send_byte(8'h34, 1);
        send_byte(8'hAB, 1); send_byte(8'hCD, 1); send_byte(8'hC0, 1);
        chk("done_not_early", pre_done, 0);
        chk("hold_not_early", pre_hold, 1);
        chk("done_next_cycle", o_done, 1);
        chk("hold_drop_next_cycle", o_core_hold, 0);

        // After DONE, a further frame is ignored
        send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h00, 1);
        send_byte(8'h01, 1); send_byte(8'h01, 1);
        settle_and_check("after_done", 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
